// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - instruction fetch stage with single-outstanding imem handshake
module instr_fetch_stage #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-3:0]   RESET_PC    = '0,
    parameter logic [WIDTH-1:0]   NOP_INSTR   = 32'h00000000,
    parameter logic [5:0]         HALT_OPCODE = 6'b111111
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-3:0] imem_addr,
    output logic             imem_req,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             imem_ack,
    output logic [WIDTH-1:0] instruction_out,
    output logic [WIDTH-3:0] progcounter_out,
    output logic             valid_out,
    input  logic             IsStall,
    input  logic             IsFlush,
    input  logic             redirect_en,
    input  logic [WIDTH-3:0] redirect_pc,
    output logic             halted,
    output logic [31:0]      fetch_count
);
    localparam int PW = WIDTH - 2;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [PW-1:0]    pcout_q, pcout_d;
    logic             valid_q, valid_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [PW-1:0]    buf_pc_q, buf_pc_d;

    logic             deliver;
    logic [WIDTH-1:0] del_instr;
    logic [PW-1:0]    del_pc;
    logic [PW-1:0]    pc_inc;

    assign pc_inc = pc_q + {{(PW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcout_d     = pcout_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        deliver     = 1'b0;
        del_instr   = imem_data;
        del_pc      = pc_q;

        // Any non-stalled cycle without a delivery presents a bubble; flush falls out of this too.
        if (!IsStall) begin
            instr_d = NOP_INSTR;
            pcout_d = '0;
            valid_d = 1'b0;
        end

        if (redirect_en) begin
            pc_d    = redirect_pc;
            state_d = S_FETCH;
        end else if (IsFlush && !IsStall) begin
            if (state_q == S_HOLD) begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (IsStall) begin
                            buf_instr_d = imem_data;
                            buf_pc_d    = pc_q;
                            state_d     = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!IsStall) begin
                        deliver   = 1'b1;
                        del_instr = buf_instr_q;
                        del_pc    = buf_pc_q;
                        state_d   = S_FETCH;
                    end
                end
                default: ;
            endcase
        end

        if (deliver) begin
            instr_d = del_instr;
            pcout_d = del_pc;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
            if (del_instr[WIDTH-1:WIDTH-6] == HALT_OPCODE) begin
                state_d = S_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pcout_q     <= '0;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcout_q     <= pcout_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign imem_req        = (state_q == S_FETCH) && !rst;
    assign imem_addr       = pc_q;
    assign instruction_out = instr_q;
    assign progcounter_out = pcout_q;
    assign valid_out       = valid_q;
    assign halted          = (state_q == S_HALT);
    assign fetch_count     = cnt_q;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - directed self-checking bench for instr_fetch_stage
module tb_instr_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        imem_ack;
    logic [31:0] instruction_out;
    logic [29:0] progcounter_out;
    logic        valid_out;
    logic        IsStall;
    logic        IsFlush;
    logic        redirect_en;
    logic [29:0] redirect_pc;
    logic        halted;
    logic [31:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;
    int req_seen;

    instr_fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_data(imem_data), .imem_ack(imem_ack),
        .instruction_out(instruction_out), .progcounter_out(progcounter_out),
        .valid_out(valid_out), .IsStall(IsStall), .IsFlush(IsFlush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] data, input logic stall,
                         input logic flush, input logic redir, input logic [29:0] rpc);
        imem_ack    = ack;
        imem_data   = data;
        IsStall     = stall;
        IsFlush     = flush;
        redirect_en = redir;
        redirect_pc = rpc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] ins, input logic [29:0] pc,
                             input logic v);
        check({tag, ".instr"}, instruction_out, ins);
        check({tag, ".pc"}, progcounter_out, pc);
        check({tag, ".valid"}, valid_out, v);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 30'h0);
        #1;
        check("req_in_reset", imem_req, 1'b0);
        tick();
        check_out("reset", 32'h0, 30'h0, 1'b0);
        check("reset.halted", halted, 1'b0);
        check("reset.count", fetch_count, 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset.req", imem_req, 1'b1);
        check("post_reset.addr", imem_addr, 30'h0);

        // zero-wait stream of four words
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + i, 1'b0, 1'b0, 1'b0, 30'h0);
            #1;
            check("stream.addr", imem_addr, 30'(i));
            tick();
            check_out("stream", 32'h1000 + i, 30'(i), 1'b1);
        end
        check("stream.count", fetch_count, 32'd4);

        // ack under stall buffers the word and freezes outputs
        drive(1'b1, 32'h2004, 1'b1, 1'b0, 1'b0, 30'h0);
        #1;
        check("stall.addr", imem_addr, 30'h4);
        tick();
        for (int i = 0; i < 2; i++) begin
            check_out("stall.frozen", 32'h1003, 30'h3, 1'b1);
            check("stall.req", imem_req, 1'b0);
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 30'h0);
            tick();
        end
        check_out("stall.frozen_last", 32'h1003, 30'h3, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();
        check_out("unstall", 32'h2004, 30'h4, 1'b1);
        check("unstall.count", fetch_count, 32'd5);
        check("unstall.addr", imem_addr, 30'h5);
        check("unstall.req", imem_req, 1'b1);

        // redirect beats a same-cycle ack
        drive(1'b1, 32'h2005, 1'b0, 1'b0, 1'b1, 30'h40);
        tick();
        check_out("redir", 32'h0, 30'h0, 1'b0);
        check("redir.addr", imem_addr, 30'h40);
        check("redir.count", fetch_count, 32'd5);

        // deliver pc 7, then flush+stall holds, then flush squashes and drops the ack
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 30'h7);
        tick();
        drive(1'b1, 32'h3007, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();
        check_out("pc7", 32'h3007, 30'h7, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 30'h0);
        tick();
        check_out("flush_stall", 32'h3007, 30'h7, 1'b1);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 30'h0);
        tick();
        check_out("flush", 32'h0, 30'h0, 1'b0);
        check("flush.addr", imem_addr, 30'h8);
        check("flush.count", fetch_count, 32'd6);

        // HALT at pc 9
        drive(1'b1, 32'h3008, 1'b0, 1'b0, 1'b0, 30'h0);
        tick();
        drive(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 1'b0, 30'h0);
        #1;
        check("halt.addr", imem_addr, 30'h9);
        tick();
        check_out("halt", 32'hFC00_0000, 30'h9, 1'b1);
        check("halt.halted", halted, 1'b1);
        check("halt.count", fetch_count, 32'd8);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 30'h0);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) req_seen++;
            tick();
        end
        check("halt.req_cycles", req_seen, 0);
        check_out("halt.bubble", 32'h0, 30'h0, 1'b0);
        check("halt.pc", imem_addr, 30'hA);
        check("halt.still", halted, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 30'h0);
        tick();
        check("resume.halted", halted, 1'b0);
        check("resume.req", imem_req, 1'b1);
        check("resume.addr", imem_addr, 30'h0);

        // reset mid-request with a late ack
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 30'hC);
        tick();
        check("pre_rst.addr", imem_addr, 30'hC);
        rst = 1'b1;
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 30'h0);
        #1;
        check("rst.req", imem_req, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 30'h0);
        #1;
        check_out("rst2", 32'h0, 30'h0, 1'b0);
        check("rst2.count", fetch_count, 32'd0);
        check("rst2.addr", imem_addr, 30'h0);
        check("rst2.req", imem_req, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
